// File: rtl/mbscore_mem_stage.sv
// mbscore_mem_stage: MEM pipeline stage of the MBScore core.
//   Registers the ALU result, runs one load/store on the data bus at a time,
//   extends load data and hands {alu_out, mem_data_in, WB_sel, wb_rd} to the WB
//   mux with a one-cycle wb_valid pulse. EX is stalled (ex_ready=0) while a bus
//   access is outstanding; an access left unacked for TIMEOUT cycles is aborted
//   and reported through bus_err.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ex_*                       instruction from EX, accepted when ex_valid & ex_ready
//   mem_req/we/addr/wdata/be   data-bus request, held until mem_ack or timeout
//   mem_ack, mem_rdata         data-bus response
//   wb_valid, WB_sel, alu_out, mem_data_in, wb_rd, misalign, bus_err
//                              completion to the WB mux (held when wb_valid=0)

// One byte lane of the store path: lane enable and lane write data.
module mbscore_mem_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  logic [7:0] byte0,     // st_data[7:0]
  input  logic [7:0] half_byte, // st_data byte this lane carries in a half store
  input  logic [7:0] word_byte, // st_data byte this lane carries in a word store
  output logic       be,
  output logic [7:0] wdata
);
  localparam logic [2:0] LN = 3'(LANE);

  logic [2:0] lo;
  assign lo = {1'b0, addr_lo};

  always_comb begin
    be    = 1'b0;
    wdata = 8'h00;
    case (size)
      2'b00: begin
        be    = (addr_lo == LN[1:0]);
        wdata = byte0;
      end
      2'b01: begin
        // 0011 << addr_lo truncated to four lanes
        be    = (lo == LN) || ((lo + 3'd1) == LN);
        wdata = half_byte;
      end
      default: begin
        be    = 1'b1;
        wdata = word_byte;
      end
    endcase
  end
endmodule

module mbscore_mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid,
  output logic                    ex_ready,
  input  logic [1:0]              ex_mem_op,
  input  logic [1:0]              ex_size,
  input  logic                    ex_unsigned,
  input  logic [1:0]              ex_WB_sel,
  input  logic [4:0]              ex_rd,
  input  logic [DATA_WIDTH-1:0]   ex_alu_out,
  input  logic [DATA_WIDTH-1:0]   ex_st_data,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    wb_valid,
  output logic [1:0]              WB_sel,
  output logic [DATA_WIDTH-1:0]   alu_out,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  output logic [4:0]              wb_rd,
  output logic                    misalign,
  output logic                    bus_err
);
  localparam int         NUM_LANES = DATA_WIDTH / 8;
  localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state;
  logic [7:0] cnt;

  // Instruction context captured at accept, used when the access completes
  logic                  p_ld;
  logic [1:0]            p_size;
  logic                  p_unsigned;
  logic [1:0]            p_addr_lo;
  logic [1:0]            p_wb_sel;
  logic [4:0]            p_rd;
  logic [DATA_WIDTH-1:0] p_alu;

  logic is_ld, is_st, misal;
  assign is_ld = (ex_mem_op == 2'b01);
  assign is_st = (ex_mem_op == 2'b10);

  always_comb begin
    case (ex_size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = ex_alu_out[0];
      default: misal = (ex_alu_out[1:0] != 2'b00);
    endcase
  end

  // Store lanes
  logic [NUM_LANES-1:0]      lane_be;
  logic [NUM_LANES-1:0][7:0] lane_wdata;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mbscore_mem_lane #(.LANE(g)) u_lane (
      .size      (ex_size),
      .addr_lo   (ex_alu_out[1:0]),
      .byte0     (ex_st_data[7:0]),
      .half_byte (ex_st_data[8*(g%2) +: 8]),
      .word_byte (ex_st_data[8*g +: 8]),
      .be        (lane_be[g]),
      .wdata     (lane_wdata[g])
    );
  end

  // Load extract: right-align the addressed byte/half, then extend
  logic [DATA_WIDTH-1:0] rd_shift, ld_ext;
  assign rd_shift = mem_rdata >> {p_addr_lo, 3'b000};

  always_comb begin
    case (p_size)
      2'b00:   ld_ext = p_unsigned ? {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]}
                                   : {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_ext = p_unsigned ? {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]}
                                   : {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ex_ready    <= 1'b1;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      wb_valid    <= 1'b0;
      WB_sel      <= '0;
      alu_out     <= '0;
      mem_data_in <= '0;
      wb_rd       <= '0;
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
      p_ld        <= 1'b0;
      p_size      <= '0;
      p_unsigned  <= 1'b0;
      p_addr_lo   <= '0;
      p_wb_sel    <= '0;
      p_rd        <= '0;
      p_alu       <= '0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if ((is_ld || is_st) && !misal) begin
              state      <= ACCESS;
              ex_ready   <= 1'b0;
              cnt        <= '0;
              mem_req    <= 1'b1;
              mem_we     <= is_st;
              mem_addr   <= {ex_alu_out[DATA_WIDTH-1:2], 2'b00};
              mem_wdata  <= lane_wdata;
              mem_be     <= lane_be;
              p_ld       <= is_ld;
              p_size     <= ex_size;
              p_unsigned <= ex_unsigned;
              p_addr_lo  <= ex_alu_out[1:0];
              p_wb_sel   <= ex_WB_sel;
              p_rd       <= ex_rd;
              p_alu      <= ex_alu_out;
            end else begin
              // No bus access: plain ALU op, reserved op, or misaligned access
              wb_valid    <= 1'b1;
              WB_sel      <= ex_WB_sel;
              alu_out     <= ex_alu_out;
              wb_rd       <= ex_rd;
              mem_data_in <= '0;
              misalign    <= is_ld || is_st;
            end
          end
        end
        ACCESS: begin
          // An ack in the final timeout cycle still completes normally
          if (mem_ack || cnt == CNT_LAST) begin
            state       <= IDLE;
            ex_ready    <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            wb_valid    <= 1'b1;
            WB_sel      <= p_wb_sel;
            alu_out     <= p_alu;
            wb_rd       <= p_rd;
            mem_data_in <= (mem_ack && p_ld) ? ld_ext : '0;
            bus_err     <= !mem_ack;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mbscore_mem_stage.sv
// Bench for mbscore_mem_stage: scoreboard of expected WB completions, one task
// per scenario, bus responses driven by hand inside each task.
module tb_mbscore_mem_stage;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid = 1'b0;
  logic          ex_ready;
  logic [1:0]    ex_mem_op = '0, ex_size = '0, ex_WB_sel = '0;
  logic          ex_unsigned = 1'b0;
  logic [4:0]    ex_rd = '0;
  logic [DW-1:0] ex_alu_out = '0, ex_st_data = '0;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          wb_valid, misalign, bus_err;
  logic [1:0]    WB_sel;
  logic [DW-1:0] alu_out, mem_data_in;
  logic [4:0]    wb_rd;

  mbscore_mem_stage #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_op(ex_mem_op), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_WB_sel(ex_WB_sel), .ex_rd(ex_rd),
    .ex_alu_out(ex_alu_out), .ex_st_data(ex_st_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .WB_sel(WB_sel), .alu_out(alu_out), .mem_data_in(mem_data_in),
    .wb_rd(wb_rd), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] mdi;
    logic [4:0]  rd;
    logic        mis;
    logic        berr;
  } wb_t;

  wb_t sb[$];
  int  n_cmp = 0, n_err = 0, n_push = 0, n_wb = 0;

  always @(negedge clk) if (rst_n && wb_valid) n_wb++;

  function automatic wb_t mk(input logic [1:0] sel, input logic [31:0] alu, mdi,
                             input logic [4:0] rd, input logic mis, berr);
    mk = {sel, alu, mdi, rd, mis, berr};
  endfunction

  task automatic push(input wb_t e);
    sb.push_back(e);
    n_push++;
  endtask

  task automatic issue(input logic [1:0] op, sz, input logic uns, input logic [1:0] sel,
                       input logic [4:0] rd, input logic [31:0] alu, st);
    ex_mem_op = op; ex_size = sz; ex_unsigned = uns; ex_WB_sel = sel;
    ex_rd = rd; ex_alu_out = alu; ex_st_data = st; ex_valid = 1'b1;
    @(posedge clk); #1 ex_valid = 1'b0;
  endtask

  // Waits (bounded) for the next wb_valid; lat counts negedges, 99 on expiry
  task automatic get_wb(output wb_t obs, output int lat, output wb_t exp);
    obs = '0; lat = 99; exp = '1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (wb_valid) begin
        obs = {WB_sel, alu_out, mem_data_in, wb_rd, misalign, bus_err};
        lat = i;
        break;
      end
    end
    if (sb.size() > 0) exp = sb.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({ex_ready, mem_req, mem_we, wb_valid, misalign, bus_err} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b need 100000",
               {ex_ready, mem_req, mem_we, wb_valid, misalign, bus_err});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_be, alu_out, mem_data_in, WB_sel, wb_rd} !== '0) begin
      n_err++;
      $display("FAIL reset_data: addr=%h wdata=%h be=%b alu=%h mdi=%h", mem_addr, mem_wdata,
               mem_be, alu_out, mem_data_in);
    end
    @(negedge clk) rst_n = 1'b1;
    // A stray ack while idle must be ignored
    mem_ack = 1'b1;
    @(negedge clk) mem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu_op();
    wb_t obs, exp; int lat;
    push(mk(2'd1, 32'h1234_5678, 32'h0, 5'd5, 1'b0, 1'b0));
    issue(2'b00, 2'b10, 1'b0, 2'd1, 5'd5, 32'h1234_5678, 32'hFFFF_FFFF);
    get_wb(obs, lat, exp);
    n_cmp++;
    if (lat !== 1 || obs !== exp) begin
      n_err++;
      $display("FAIL alu_op: lat=%0d got %h need lat=1 %h", lat, obs, exp);
    end
    n_cmp++;
    if ({ex_ready, mem_req} !== 2'b10) begin
      n_err++;
      $display("FAIL alu_ready: ex_ready/mem_req=%b need 10", {ex_ready, mem_req});
    end
    // Reserved op behaves as no memory op
    push(mk(2'd3, 32'hA5A5_0001, 32'h0, 5'd31, 1'b0, 1'b0));
    issue(2'b11, 2'b00, 1'b1, 2'd3, 5'd31, 32'hA5A5_0001, 32'h0);
    get_wb(obs, lat, exp);
    n_cmp++;
    if (lat !== 1 || obs !== exp || mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL rsvd_op: lat=%0d req=%b got %h need %h", lat, mem_req, obs, exp);
    end
    @(negedge clk);
    n_cmp++;
    if ({wb_valid, alu_out, WB_sel, wb_rd} !== {1'b0, 32'hA5A5_0001, 2'd3, 5'd31}) begin
      n_err++;
      $display("FAIL wb_hold: vld=%b alu=%h sel=%0d rd=%0d need 0 a5a50001 3 31",
               wb_valid, alu_out, WB_sel, wb_rd);
    end
  endtask

  typedef struct packed {
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] mdi;
    logic [2:0]  dly;
  } ld_t;

  task automatic test_loads();
    ld_t tbl[7];
    wb_t obs, exp; int lat;
    tbl = '{'{2'd0, 1'b0, 32'h103, 32'h80AA_BBCC, 4'b1000, 32'hFFFF_FF80, 3'd3},
            '{2'd0, 1'b1, 32'h101, 32'h80AA_BBCC, 4'b0010, 32'h0000_00BB, 3'd1},
            '{2'd1, 1'b0, 32'h102, 32'h80AA_BBCC, 4'b1100, 32'hFFFF_80AA, 3'd2},
            '{2'd1, 1'b1, 32'h100, 32'h1234_F678, 4'b0011, 32'h0000_F678, 3'd1},
            '{2'd2, 1'b0, 32'h104, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 3'd4},
            '{2'd3, 1'b0, 32'h108, 32'h8765_4321, 4'b1111, 32'h8765_4321, 3'd1},
            '{2'd0, 1'b0, 32'h100, 32'h0000_007F, 4'b0001, 32'h0000_007F, 3'd2}};
    foreach (tbl[i]) begin
      push(mk(2'd2, tbl[i].addr, tbl[i].mdi, 5'(i + 3), 1'b0, 1'b0));
      issue(2'b01, tbl[i].sz, tbl[i].uns, 2'd2, 5'(i + 3), tbl[i].addr, 32'h0);
      @(negedge clk);
      n_cmp++;
      if ({mem_req, mem_we, ex_ready, mem_addr, mem_be} !==
          {3'b100, tbl[i].addr & 32'hFFFF_FFFC, tbl[i].be}) begin
        n_err++;
        $display("FAIL ld_bus[%0d]: req=%b we=%b rdy=%b addr=%h be=%b need 1 0 0 %h %b", i,
                 mem_req, mem_we, ex_ready, mem_addr, mem_be, tbl[i].addr & 32'hFFFF_FFFC,
                 tbl[i].be);
      end
      repeat (int'(tbl[i].dly) - 1) @(negedge clk);
      mem_ack = 1'b1; mem_rdata = tbl[i].rdata;
      @(posedge clk); #1 mem_ack = 1'b0; mem_rdata = $urandom;
      get_wb(obs, lat, exp);
      n_cmp++;
      if (lat !== 1 || obs !== exp || {mem_req, ex_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL ld_wb[%0d]: lat=%0d req=%b rdy=%b got %h need %h", i, lat, mem_req,
                 ex_ready, obs, exp);
      end
    end
  endtask

  task automatic test_stores();
    logic [1:0]  sz[4]    = '{2'd1, 2'd0, 2'd2, 2'd1};
    logic [31:0] addr[4]  = '{32'h102, 32'h101, 32'h108, 32'h100};
    logic [31:0] st[4]    = '{32'hDEAD_BEEF, 32'h1234_56A5, 32'hDEAD_BEEF, 32'h0000_1234};
    logic [3:0]  be[4]    = '{4'b1100, 4'b0010, 4'b1111, 4'b0011};
    logic [31:0] wd[4]    = '{32'hBEEF_BEEF, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'h1234_1234};
    wb_t obs, exp; int lat;
    for (int i = 0; i < 4; i++) begin
      push(mk(2'd0, addr[i], 32'h0, 5'd9, 1'b0, 1'b0));
      issue(2'b10, sz[i], 1'b0, 2'd0, 5'd9, addr[i], st[i]);
      @(negedge clk);
      n_cmp++;
      if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !==
          {2'b11, addr[i] & 32'hFFFF_FFFC, be[i], wd[i]}) begin
        n_err++;
        $display("FAIL st_bus[%0d]: req=%b we=%b addr=%h be=%b wdata=%h need 1 1 %h %b %h", i,
                 mem_req, mem_we, mem_addr, mem_be, mem_wdata, addr[i] & 32'hFFFF_FFFC,
                 be[i], wd[i]);
      end
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1 mem_ack = 1'b0;
      get_wb(obs, lat, exp);
      n_cmp++;
      if (lat !== 1 || obs !== exp) begin
        n_err++;
        $display("FAIL st_wb[%0d]: lat=%0d got %h need %h", i, lat, obs, exp);
      end
    end
  endtask

  task automatic test_misalign();
    logic [1:0]  op[3]   = '{2'b01, 2'b01, 2'b10};
    logic [1:0]  sz[3]   = '{2'd2, 2'd1, 2'd2};
    logic [31:0] addr[3] = '{32'h101, 32'h103, 32'h102};
    wb_t obs, exp; int lat;
    for (int i = 0; i < 3; i++) begin
      push(mk(2'd1, addr[i], 32'h0, 5'd12, 1'b1, 1'b0));
      issue(op[i], sz[i], 1'b0, 2'd1, 5'd12, addr[i], 32'h5555_AAAA);
      get_wb(obs, lat, exp);
      n_cmp++;
      if (lat !== 1 || obs !== exp || mem_req !== 1'b0 || ex_ready !== 1'b1) begin
        n_err++;
        $display("FAIL misalign[%0d]: lat=%0d req=%b rdy=%b got %h need %h", i, lat, mem_req,
                 ex_ready, obs, exp);
      end
    end
  endtask

  task automatic test_timeout();
    wb_t obs, exp; int n_req = 0; bit seen = 0;
    push(mk(2'd2, 32'h200, 32'h0, 5'd20, 1'b0, 1'b1));
    issue(2'b01, 2'd2, 1'b0, 2'd2, 5'd20, 32'h200, 32'h0);
    obs = '0;
    for (int i = 0; i < 3 * TO; i++) begin
      @(negedge clk);
      if (wb_valid) begin
        obs = {WB_sel, alu_out, mem_data_in, wb_rd, misalign, bus_err};
        seen = 1;
        break;
      end
      if (mem_req) n_req++;
    end
    exp = (sb.size() > 0) ? sb.pop_front() : '1;
    n_cmp++;
    if (!seen || n_req != TO || obs !== exp || {mem_req, ex_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL timeout: seen=%0d req_cycles=%0d need %0d req=%b rdy=%b got %h need %h",
               seen, n_req, TO, mem_req, ex_ready, obs, exp);
    end
    // Ack in the very last allowed cycle wins over the timeout
    push(mk(2'd2, 32'h204, 32'hFFFF_FFEE, 5'd21, 1'b0, 1'b0));
    issue(2'b01, 2'd0, 1'b0, 2'd2, 5'd21, 32'h204, 32'h0);
    repeat (TO) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h0000_00EE;
    @(posedge clk); #1 mem_ack = 1'b0;
    begin
      int lat;
      get_wb(obs, lat, exp);
      n_cmp++;
      if (lat !== 1 || obs !== exp) begin
        n_err++;
        $display("FAIL ack_at_timeout: lat=%0d got %h need %h", lat, obs, exp);
      end
    end
  endtask

  task automatic test_reset_in_access();
    int seen = 0;
    issue(2'b01, 2'd2, 1'b0, 2'd1, 5'd7, 32'h300, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, ex_ready, wb_valid} !== 3'b010) begin
      n_err++;
      $display("FAIL rst_access: req/rdy/vld=%b need 010", {mem_req, ex_ready, wb_valid});
    end
    @(negedge clk) rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (wb_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL late_ack: wb_valid pulses=%0d need 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    wb_t obs, exp;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        obs = {WB_sel, alu_out, mem_data_in, wb_rd, misalign, bus_err};
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        n_cmp++;
        if (wb_valid !== 1'b1 || obs !== exp) begin
          n_err++;
          $display("FAIL b2b[%0d]: vld=%b got %h need %h", i, wb_valid, obs, exp);
        end
      end
      if (i < 4) begin
        ex_alu_out = $urandom; ex_WB_sel = 2'(i); ex_rd = 5'(i + 1);
        ex_mem_op = 2'b00; ex_valid = 1'b1;
        push(mk(ex_WB_sel, ex_alu_out, 32'h0, ex_rd, 1'b0, 1'b0));
      end else begin
        ex_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_in_access();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_wb != n_push || sb.size() != 0) begin
      n_err++;
      $display("FAIL wb_count: pulses=%0d expected=%0d left_in_queue=%0d", n_wb, n_push,
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
